// File: rtl/rv32i_mem_pkg.sv
// Shared types and default widths for the RV32I instruction/data SRAM arbiter.
// The owner tag marks which port, if any, is waiting on the SRAM read issued last cycle.
package rv32i_mem_pkg;

    localparam int DEF_WORD_WTH   = 32;
    localparam int DEF_ADDR_WTH   = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Wide enough for the largest legal STARVE_MAX (15)
    localparam int STARVE_CNT_WTH = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-port SRAM between an instruction-fetch port and a data port.
// Data wins by default; a starved fetch port is forced through after STARVE_MAX denials.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int WORD_WTH   = DEF_WORD_WTH,
    parameter int ADDR_WTH   = DEF_ADDR_WTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_WTH-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_WTH-1:0] i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_WTH-1:0] d_addr,
    input  logic [WORD_WTH-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_WTH-1:0] d_rdata,

    output logic                sram_en,
    output logic                sram_we,
    output logic [ADDR_WTH-3:0] sram_addr,
    output logic [WORD_WTH-1:0] sram_wdata,
    input  logic [WORD_WTH-1:0] sram_rdata
);

    localparam logic [STARVE_CNT_WTH-1:0] STARVE_LIM = STARVE_CNT_WTH'(STARVE_MAX);

    logic [STARVE_CNT_WTH-1:0] starve_cnt;
    logic [STARVE_CNT_WTH-1:0] starve_nxt;
    owner_t                    owner;
    owner_t                    owner_nxt;
    logic                      force_i;

    // Word-aligned SRAM: the byte-offset bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            owner      <= OWN_NONE;
        end else begin
            starve_cnt <= starve_nxt;
            owner      <= owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        force_i    = 1'b0;
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        starve_nxt = starve_cnt;
        owner_nxt  = OWN_NONE;

        if (rst) begin
            force_i = i_req && (starve_cnt == STARVE_LIM);
            d_gnt   = d_req && !force_i;
            i_gnt   = i_req && !d_gnt;
        end

        if (!i_req || i_gnt) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_nxt = starve_cnt + 1'b1;
        end

        // Stores produce no read data, so they leave no owner behind
        if (i_gnt) begin
            owner_nxt = OWN_I;
        end else if (d_gnt && !d_we) begin
            owner_nxt = OWN_D;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: SRAM command and read-data routing
    // ------------------------------------------------------------------
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;

        if (d_gnt) begin
            sram_en    = 1'b1;
            sram_we    = d_we;
            sram_addr  = d_addr[ADDR_WTH-1:2];
            sram_wdata = d_wdata;
        end else if (i_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = i_addr[ADDR_WTH-1:2];
        end
    end

    // A reset arriving while a read is in flight drops that read outright.
    always_comb begin
        i_rvalid = rst && (owner == OWN_I);
        d_rvalid = rst && (owner == OWN_D);
        i_rdata  = i_rvalid ? sram_rdata : '0;
        d_rdata  = d_rvalid ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a behavioural SRAM and an rdata scoreboard.
module tb_rv32i_mem_arbiter;

    localparam int W  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [W-1:0]  i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [W-1:0]  d_wdata;
    logic          d_gnt, d_rvalid;
    logic [W-1:0]  d_rdata;
    logic          sram_en, sram_we;
    logic [AW-3:0] sram_addr;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [W-1:0] i_exp_q[$];
    logic [W-1:0] d_exp_q[$];
    int           i_cyc_q[$];
    int           d_cyc_q[$];

    logic [W-1:0] mem [0:255];

    rv32i_mem_arbiter #(.WORD_WTH(W), .ADDR_WTH(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model (1-cycle read) ----------------
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive, check combinational outputs, advance one cycle.
    task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [W-1:0] dwd, input logic eig, input logic edg,
                        input logic [W-1:0] eaddr, input logic [W-1:0] erd);
        rst = r; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
        chk("i_gnt", W'(i_gnt), W'(eig));
        chk("d_gnt", W'(d_gnt), W'(edg));
        chk("sram_en", W'(sram_en), W'(eig | edg));
        chk("sram_we", W'(sram_we), W'(edg & dw));
        chk("sram_addr", W'(sram_addr), eaddr);
        chk("sram_wdata", sram_wdata, edg ? dwd : '0);
        if (eig) begin
            i_exp_q.push_back(erd); i_cyc_q.push_back(cyc + 1);
        end else if (edg && !dw) begin
            d_exp_q.push_back(erd); d_cyc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_starve(input int exp);
        chk("starve_cnt", W'(dut.starve_cnt), W'(exp));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (i_gnt && d_gnt) chk("dual_grant", 32'd1, 32'd0);
        if (i_rvalid) begin
            if (i_exp_q.size() == 0) begin
                chk("i_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("i_rdata", i_rdata, i_exp_q.pop_front());
                chk("i_latency", W'(cyc), W'(i_cyc_q.pop_front()));
                chk("d_rdata_idle", d_rdata, '0);
            end
        end
        if (d_rvalid) begin
            if (d_exp_q.size() == 0) begin
                chk("d_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("d_rdata", d_rdata, d_exp_q.pop_front());
                chk("d_latency", W'(cyc), W'(d_cyc_q.pop_front()));
                chk("i_rdata_idle", i_rdata, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hA500_0000 + k;
        sram_rdata = '0;
        rst = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(posedge clk); #1;

        // Reset: requests ignored, grants and SRAM controls held low
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h1, 1'b0, 1'b0, '0, '0);
        check_starve(0);
        chk("owner_rst", W'(dut.owner), 32'd0);
        chk("i_rvalid_rst", W'(i_rvalid), 32'd0);
        chk("d_rvalid_rst", W'(d_rvalid), 32'd0);
        chk("i_rdata_rst", i_rdata, '0);
        chk("d_rdata_rst", d_rdata, '0);

        // Fetch only: three back-to-back reads of 0x100 -> word 0x40
        repeat (3) step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h40, 32'hA500_0040);
        idle();

        // Conflict then starvation: data wins four times, fetch forced on the fifth
        step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h200, '0, 1'b0, 1'b1, 32'h80, 32'hA500_0080);
        check_starve(1);
        repeat (3) step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h200, '0, 1'b0, 1'b1, 32'h80, 32'hA500_0080);
        check_starve(4);
        step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h200, '0, 1'b1, 1'b0, 32'h41, 32'hA500_0041);
        check_starve(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h200, '0, 1'b0, 1'b1, 32'h80, 32'hA500_0080);
        idle();

        // Store then load back; address low bits ignored on the load
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h4, '0);
        idle();
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h13, '0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
        idle();

        // Alternating data / fetch / data
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h200, '0, 1'b0, 1'b1, 32'h80, 32'hA500_0080);
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h40, 32'hA500_0040);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
        idle();

        // Reset mid-read: the granted fetch must never be returned
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h40, 32'hA500_0040);
        void'(i_exp_q.pop_back());
        void'(i_cyc_q.pop_back());
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        #1;
        chk("i_rvalid_mid_rst", W'(i_rvalid), 32'd0);
        chk("d_rvalid_mid_rst", W'(d_rvalid), 32'd0);
        chk("i_gnt_mid_rst", W'(i_gnt), 32'd0);
        chk("sram_en_mid_rst", W'(sram_en), 32'd0);
        @(posedge clk); #1;
        check_starve(0);
        idle();
        idle();

        chk("i_queue_left", W'(i_exp_q.size()), 32'd0);
        chk("d_queue_left", W'(d_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
